// File: rtl/button_pkg.sv
// Shared types for the button gesture classifier.
//   btn_state_t : FSM encoding used by button_event.
package button_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_HELD
    } btn_state_t;

endpackage

// File: rtl/button_event_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every
// TICK_CYCLES enabled clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, counter restarts at 0 (wins over en)
//   en    : count enable
//   tick  : high while the counter sits at TICK_CYCLES-1 and en is high
module tick_gen #(
    parameter int TICK_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en & (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/button_event.sv
// button_event: turns one debounced button level into single-cycle gesture
// pulses (press, release, click, long-press, auto-repeat) plus a held level.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   clean     : debounced button level in the clk domain, 1 = pressed
//   press_p   : pulse on press
//   release_p : pulse on release
//   click_p   : pulse on release before the hold threshold
//   long_p    : pulse when the hold threshold is reached
//   repeat_p  : auto-repeat pulse every REPEAT_TICKS ticks while held
//   held      : level, high while in the HELD state
module button_event
    import button_pkg::*;
#(
    parameter int TICK_CYCLES  = 100_000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

    btn_state_t    state_q, state_d;
    logic          clean_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          press_d, release_d, click_d, long_d, repeat_d, held_d;
    logic          rise, fall, tick, presc_clr;

    assign rise = clean & ~clean_q;
    assign fall = ~clean & clean_q;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .en   (state_q != BTN_IDLE),
        .tick (tick)
    );

    // Threshold decisions fire on the edge where the counter would reach its
    // limit, so the pulse lands exactly N*TICK_CYCLES after the reference
    // pulse. A fall on that same edge takes priority.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        presc_clr = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                if (rise) begin
                    state_d   = BTN_PRESSED;
                    press_d   = 1'b1;
                    presc_clr = 1'b1;
                    hold_d    = '0;
                end
            end
            BTN_PRESSED: begin
                if (fall) begin
                    state_d   = BTN_IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = BTN_HELD;
                        long_d  = 1'b1;
                        hold_d  = HOLD_MAX;
                        rep_d   = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            BTN_HELD: begin
                if (fall) begin
                    state_d   = BTN_IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
            default: state_d = BTN_IDLE;
        endcase
        held_d = (state_d == BTN_HELD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BTN_IDLE;
            clean_q   <= 1'b0;
            hold_q    <= '0;
            rep_q     <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            long_p    <= 1'b0;
            repeat_p  <= 1'b0;
            held      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clean_q   <= clean;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_p   <= press_d;
            release_p <= release_d;
            click_p   <= click_d;
            long_p    <= long_d;
            repeat_p  <= repeat_d;
            held      <= held_d;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with TICK_CYCLES=4, HOLD_TICKS=5,
// REPEAT_TICKS=3: long_p lands 20 cycles after press_p, repeats every 12.
module tb_button_event;

    localparam int LONG_AT   = 20;
    localparam int REP_EVERY = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic clean;
    logic press_p, release_p, click_p, long_p, repeat_p, held;
    logic [5:0] outs;
    int checks = 0;
    int errors = 0;

    assign outs = {press_p, release_p, click_p, long_p, repeat_p, held};

    button_event #(
        .TICK_CYCLES (4),
        .HOLD_TICKS  (5),
        .REPEAT_TICKS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clean    (clean),
        .press_p  (press_p),
        .release_p(release_p),
        .click_p  (click_p),
        .long_p   (long_p),
        .repeat_p (repeat_p),
        .held     (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed {prs,rel,clk,long,rep,held}=%b expected %b", tag, k, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the edge that sampled the press, for a
    // press whose first clean=0 is sampled on edge `len`.
    function automatic logic [5:0] expv(input int k, input int len);
        logic p, r, c, l, rp, h;
        logic lng;
        lng = (len > LONG_AT);
        p   = (k == 0);
        r   = (k == len);
        c   = r && !lng;
        l   = lng && (k == LONG_AT);
        rp  = lng && (k > LONG_AT) && (k < len) && (((k - LONG_AT) % REP_EVERY) == 0);
        h   = lng && (k >= LONG_AT) && (k < len);
        return {p, r, c, l, rp, h};
    endfunction

    // Drive clean high, drop it before edge `len`, check n post-edge samples.
    task automatic run(input string tag, input int len, input int n);
        clean = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == len) clean = 1'b0;
            @(posedge clk); #1;
            chk(tag, k, outs, expv(k, len));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clean = 1'b0;
        #12;
        chk("reset", 0, outs, 6'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle", k, outs, 6'b0);
        end

        run("short", 10, 12);
        run("below_thr", 19, 21);
        run("collide", LONG_AT, LONG_AT + 2);
        run("above_thr", 21, 23);
        run("long", 50, 52);
        run("rep_collide", 32, 34);

        // Async reset while HELD, clean kept high through deassertion.
        run("rst_pre", 1000, 26);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, outs, 6'b0);
        @(posedge clk); #1;
        chk("rst_hold", 0, outs, 6'b0);
        rst_n = 1'b1;
        run("rst_post", 30, 32);

        // Release then re-press one cycle later.
        run("b2b_a", 25, 26);
        run("b2b_b", 30, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
# button_event

Button gesture classifier sitting directly downstream of the debounced button level. Converts one clean, synchronous active-high button level into single-cycle event pulses: press, release, click (short press), long-press, and auto-repeat while held. One instance per button; game-control logic consumes only the pulses and never the raw level.

## Interface

- `TICK_CYCLES`, default 100_000: clock cycles per timing tick (1 ms at 10 ns clock); must be ≥1.
- `HOLD_TICKS`, default 500: ticks of continuous press before `long_p`; must be ≥1.
- `REPEAT_TICKS`, default 100: ticks between successive `repeat_p` after `long_p`; must be ≥1.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `clean`  input  1  debounced button level, synchronous to `clk`, 1 = pressed.
- `press_p`  output  1  one-cycle pulse on press.
- `release_p`  output  1  one-cycle pulse on release.
- `click_p`  output  1  one-cycle pulse on release before long-press threshold.
- `long_p`  output  1  one-cycle pulse when hold threshold is reached.
- `repeat_p`  output  1  one-cycle auto-repeat pulse while long-held.
- `held`  output  1  level, high while in HELD state.

## Operation

- Input registered once (`clean_q`, reset 0); rise = `clean & ~clean_q`, fall = `~clean & clean_q`. No synchronizer; `clean` is already in the `clk` domain.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE: on rise → PRESSED, assert `press_p`, clear tick prescaler and hold counter.
  - PRESSED: count ticks; when hold counter reaches `HOLD_TICKS` → HELD, assert `long_p`, clear repeat counter. On fall → IDLE, assert `release_p` and `click_p`.
  - HELD: count ticks; every `REPEAT_TICKS` ticks assert `repeat_p`, repeat counter wraps to 0. On fall → IDLE, assert `release_p` only (no `click_p`).
- Priority: fall beats threshold. Fall sampled on the same edge the hold threshold would be reached → `release_p` + `click_p`, no `long_p`. Same rule for `repeat_p` in HELD.
- Prescaler counts 0..`TICK_CYCLES-1`, tick when at max; runs only in PRESSED/HELD, cleared on press.
- Counter widths: `$clog2(N+1)` of their limit; hold counter never exceeds `HOLD_TICKS`.
- `repeat_p` never asserts before `long_p` of the same press.

## Timing

- All outputs registered; reset value 0 for every output, state IDLE, all counters 0.
- `press_p` high in the cycle following the first edge sampling `clean=1` after `clean_q=0`; `release_p`/`click_p` likewise for the first `clean=0`.
- `long_p` exactly `HOLD_TICKS*TICK_CYCLES` cycles after `press_p`.
- `repeat_p` exactly `k*REPEAT_TICKS*TICK_CYCLES` cycles after `long_p`, k = 1, 2, …
- `held` rises with `long_p`, falls with `release_p`.
- Reset mid-operation: all outputs drop to 0 immediately, without a clock. If `clean` is still 1 at deassertion, `press_p` fires on the first edge and timing restarts.
- Release followed by press one cycle later: a full new press with fresh timing; no events carry over.

## Structure

- Shared package `button_pkg`: `typedef enum logic [1:0] {BTN_IDLE, BTN_PRESSED, BTN_HELD} btn_state_t`.
- One sub-module `tick_gen`: prescaler with synchronous clear input and one-cycle `tick` output, parameterized by `TICK_CYCLES`.
- FSM, hold counter, and repeat counter live in `button_event`.

## Test plan

Bench parameters: `TICK_CYCLES=4`, `HOLD_TICKS=5`, `REPEAT_TICKS=3` (`long_p` at +20 cycles, repeat every 12).

- **Short press.** `clean` high 10 cycles → one `press_p`; at +10, `release_p` + `click_p` together; no `long_p`, `repeat_p`, or `held`.
- **Long hold.** `clean` high 50 cycles → `long_p` + `held` at +20, `repeat_p` at +32 and +44, `release_p` at +50 without `click_p`, `held` low at +50.
- **Threshold collision.** First `clean=0` sampled on the +20 edge → `release_p` + `click_p`; `long_p` never asserts.
- **Async reset mid-HELD.** Drop `rst_n` between edges → all outputs 0 before the next edge. With `clean` held 1 through deassertion → `press_p` on first edge, `long_p` 20 cycles later.
- **Back-to-back.** Release then re-press one cycle apart → `release_p`, then `press_p` on the next cycle; `long_p` exactly +20 from the new `press_p`.
